// File: rtl/music_mul_rr_sched.sv
// Round-robin scheduler sharing one unsigned x signed multiplier among NUM_REQ requesters.
// Products travel a MUL_STAGES-deep pipeline that only advances as a whole.
module music_mul_rr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 15,
  parameter int P_WIDTH    = 15,
  parameter int MUL_STAGES = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [P_WIDTH-1:0]           rsp_p
);

  localparam int PROD_W = A_WIDTH + 1 + B_WIDTH;

  logic [MUL_STAGES-1:0] vld_q, vld_d;
  logic [ID_WIDTH-1:0]   id_q [MUL_STAGES];
  logic [ID_WIDTH-1:0]   id_d [MUL_STAGES];
  logic [P_WIDTH-1:0]    p_q  [MUL_STAGES];
  logic [P_WIDTH-1:0]    p_d  [MUL_STAGES];
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic                  advance;
  logic                  gnt_found;
  logic                  grant;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [NUM_REQ-1:0]    rot;
  logic [ID_WIDTH:0]     sum;
  logic [A_WIDTH-1:0]    a_sel;
  logic [B_WIDTH-1:0]    b_sel;
  logic [P_WIDTH-1:0]    prod_lo;

  assign advance = !vld_q[MUL_STAGES-1] || rsp_ready;

  // Rotate so bit k of rot is requester (ptr+k) mod NUM_REQ; first set bit wins.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(k);
        if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
          sum = sum - (ID_WIDTH+1)'(NUM_REQ);
        end
        gnt_idx = sum[ID_WIDTH-1:0];
      end
    end
  end

  assign grant = gnt_found && advance && !ap_rst;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (gnt_idx == ID_WIDTH'(i))) begin
        req_ready[i] = 1'b1;
        a_sel        = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel        = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  // a zero-extended, b sign-extended; only the low P_WIDTH bits are kept.
  assign prod_lo = P_WIDTH'(PROD_W'(a_sel) * PROD_W'($signed(b_sel)));

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    p_d   = p_q;
    ptr_d = ptr_q;
    if (advance) begin
      vld_d[0] = grant;
      id_d[0]  = gnt_idx;
      p_d[0]   = prod_lo;
      for (int s = 1; s < MUL_STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
        p_d[s]   = p_q[s-1];
      end
    end
    if (grant) begin
      ptr_d = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int s = 0; s < MUL_STAGES; s++) begin
        id_q[s] <= '0;
        p_q[s]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      for (int s = 0; s < MUL_STAGES; s++) begin
        id_q[s] <= id_d[s];
        p_q[s]  <= p_d[s];
      end
    end
  end

  assign rsp_valid = vld_q[MUL_STAGES-1];
  assign rsp_id    = id_q[MUL_STAGES-1];
  assign rsp_p     = p_q[MUL_STAGES-1];

endmodule
